// File: rtl/reg_file_param.sv
// Purpose: parametrised register file (2 async reads, 1 clocked write) with a streaming dump engine.
// Latency: reads combinational (optional write bypass), writes land on the next clk rise.
// Backpressure: dump beats hold index and valid while dump_ready is low; read/write ports never stall.
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done
);
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } dump_state_t;

    logic [DATA_W-1:0] regs [NUM_REGS];
    dump_state_t       state;
    dump_state_t       state_nxt;
    logic [ADDR_W-1:0] idx_nxt;
    logic              wr_en;

    // Writes to the hardwired zero register are dropped here so neither storage nor bypass sees them.
    assign wr_en = reg_write && !((ZERO_REG != 0) && (wr_addr == '0));

    // Register array: reset loads each entry with its own index, otherwise one write per clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= DATA_W'(i);
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read port A: zero register first, then same-cycle bypass, then stored value.
    always_comb begin
        rs_data = regs[rs_addr];
        if ((ZERO_REG != 0) && (rs_addr == '0)) begin
            rs_data = '0;
        end else if ((BYPASS != 0) && wr_en && (wr_addr == rs_addr)) begin
            rs_data = wr_data;
        end
    end

    // Read port B: same priority as port A.
    always_comb begin
        rt_data = regs[rt_addr];
        if ((ZERO_REG != 0) && (rt_addr == '0)) begin
            rt_data = '0;
        end else if ((BYPASS != 0) && wr_en && (wr_addr == rt_addr)) begin
            rt_data = wr_data;
        end
    end

    // Dump data is the live array value, deliberately without bypass.
    assign dump_data = regs[dump_idx];

    // Dump engine state and index registers; reset aborts any dump without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            dump_idx <= '0;
        end else begin
            state    <= state_nxt;
            dump_idx <= idx_nxt;
        end
    end

    // Dump engine next state and Moore outputs; start requests outside IDLE are dropped.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = dump_idx;
        dump_valid = 1'b0;
        dump_busy  = 1'b0;
        dump_done  = 1'b0;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_nxt = DUMP;
                    idx_nxt   = '0;
                end
            end
            DUMP: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
                if (dump_ready) begin
                    if (dump_idx == LAST_IDX) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = dump_idx + 1'b1;
                    end
                end
            end
            DONE: begin
                dump_done = 1'b1;
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end
endmodule
